tri_ingress_fifo: RTL and testbench

Triangle ingress buffer at the head of the rasterizer. It receives triangles and colors from the triangle source (driver or upstream geometry) on the R10 interface and throttles that source with `halt_RnnnnL`. It buffers up to DEPTH triangles and presents them in order, in show-ahead form, to the bounding-box stage on an R11 valid/halt interface. This decouples bbox stalls from the source's issue cadence.

---
 rtl/tri_ingress_fifo.sv | 143 ++++++++++++++
 tb/tb_tri_ingress_fifo.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/tri_ingress_fifo.sv
// ---------------------------------------------------------------------------
// tri_ingress_fifo
//   Triangle ingress buffer at the head of the rasterizer. It accepts
//   triangles and colors from the source (R10) and throttles the source with
//   halt_RnnnnL. Up to DEPTH triangles are stored and presented in order, in
//   show-ahead form, to the bounding-box stage (R11).
//
// Ports
//   clk               : single clock, rising edge
//   rst               : synchronous active-high reset
//   tri_R10S          : incoming vertices [VERTS][AXIS], SIGFIG-bit signed
//   color_R10U        : incoming color [COLORS], SIGFIG-bit unsigned
//   validTri_R10H     : incoming triangle valid
//   halt_RnnnnL       : to source, 1 = a free slot exists (registered)
//   tri_R11S          : head-entry vertices (show-ahead)
//   color_R11U        : head-entry color (show-ahead)
//   validTri_R11H     : head entry valid
//   bbox_halt_RnnnnL  : from bbox, 1 = bbox accepts this cycle
//   occupancy_RnnnnU  : current entry count
//   tri_count_RnnnnU  : triangles accepted since reset, wraps mod 2^32
// ---------------------------------------------------------------------------
module tri_ingress_fifo #(
    parameter int SIGFIG = 24,
    parameter int RADIX  = 10,
    parameter int VERTS  = 3,
    parameter int AXIS   = 3,
    parameter int COLORS = 3,
    parameter int DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic signed [SIGFIG-1:0]      tri_R10S [VERTS][AXIS],
    input  logic        [SIGFIG-1:0]      color_R10U [COLORS],
    input  logic                          validTri_R10H,
    output logic                          halt_RnnnnL,
    output logic signed [SIGFIG-1:0]      tri_R11S [VERTS][AXIS],
    output logic        [SIGFIG-1:0]      color_R11U [COLORS],
    output logic                          validTri_R11H,
    input  logic                          bbox_halt_RnnnnL,
    output logic [$clog2(DEPTH):0]        occupancy_RnnnnU,
    output logic [31:0]                   tri_count_RnnnnU
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE_C = CW'(1);
    localparam logic [PW-1:0] PTR_ONE_C = PW'(1);

    // RADIX only describes the fixed-point format; it must leave an integer part.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || RADIX >= SIGFIG) begin : g_param_check
        $fatal(1, "tri_ingress_fifo: illegal parameter set");
    end

    logic signed [SIGFIG-1:0] mem_tri_q   [DEPTH][VERTS][AXIS];
    logic        [SIGFIG-1:0] mem_color_q [DEPTH][COLORS];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          halt_q, halt_d;
    logic [31:0]   tri_count_q, tri_count_d;
    logic          push_s;
    logic          pop_s;

    // Handshake decode and next-state for pointers, count, halt and accept counter.
    always_comb begin
        // halt_q high guarantees room at this edge even without a pop.
        push_s      = validTri_R10H & halt_q;
        pop_s       = (count_q != '0) & bbox_halt_RnnnnL;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        tri_count_d = tri_count_q;
        if (push_s) begin
            wr_ptr_d    = wr_ptr_q + PTR_ONE_C;
            tri_count_d = tri_count_q + 32'd1;
        end else begin
            wr_ptr_d    = wr_ptr_q;
            tri_count_d = tri_count_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE_C;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE_C;
            2'b01:   count_d = count_q - CNT_ONE_C;
            default: count_d = count_q;
        endcase
        // Looking at the post-edge count lets the source push next cycle unconditionally.
        halt_d = (count_d < DEPTH_C);
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            halt_q      <= 1'b0;
            tri_count_q <= 32'd0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            halt_q      <= halt_d;
            tri_count_q <= tri_count_d;
        end
    end

    // Entry storage; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (push_s && !rst) begin
            for (int v = 0; v < VERTS; v++) begin
                for (int a = 0; a < AXIS; a++) begin
                    mem_tri_q[wr_ptr_q][v][a] <= tri_R10S[v][a];
                end
            end
            for (int c = 0; c < COLORS; c++) begin
                mem_color_q[wr_ptr_q][c] <= color_R10U[c];
            end
        end
    end

    // Show-ahead read of the head entry.
    always_comb begin
        for (int v = 0; v < VERTS; v++) begin
            for (int a = 0; a < AXIS; a++) begin
                tri_R11S[v][a] = mem_tri_q[rd_ptr_q][v][a];
            end
        end
        for (int c = 0; c < COLORS; c++) begin
            color_R11U[c] = mem_color_q[rd_ptr_q][c];
        end
    end

    assign halt_RnnnnL      = halt_q;
    assign validTri_R11H    = (count_q != '0);
    assign occupancy_RnnnnU = count_q;
    assign tri_count_RnnnnU = tri_count_q;

endmodule

// File: tb/tb_tri_ingress_fifo.sv
// ---------------------------------------------------------------------------
// tb_tri_ingress_fifo
//   Scoreboard bench: accepted triangle ids are queued when the source push
//   happens and compared against the head entry when bbox pops it. Control
//   outputs are compared every cycle against a small reference model.
// ---------------------------------------------------------------------------
module tb_tri_ingress_fifo;

    localparam int SIGFIG = 24;
    localparam int VERTS  = 3;
    localparam int AXIS   = 3;
    localparam int COLORS = 3;
    localparam int DEPTH  = 4;
    localparam int FW     = (VERTS * AXIS + COLORS) * SIGFIG;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                     rst;
    logic signed [SIGFIG-1:0] tri_in [VERTS][AXIS];
    logic        [SIGFIG-1:0] color_in [COLORS];
    logic                     vin;
    logic                     halt_out;
    logic signed [SIGFIG-1:0] tri_out [VERTS][AXIS];
    logic        [SIGFIG-1:0] color_out [COLORS];
    logic                     valid_out;
    logic                     bbox;
    logic [2:0]               occ;
    logic [31:0]              tcount;

    tri_ingress_fifo #(
        .SIGFIG(SIGFIG), .RADIX(10), .VERTS(VERTS), .AXIS(AXIS),
        .COLORS(COLORS), .DEPTH(DEPTH)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .tri_R10S         (tri_in),
        .color_R10U       (color_in),
        .validTri_R10H    (vin),
        .halt_RnnnnL      (halt_out),
        .tri_R11S         (tri_out),
        .color_R11U       (color_out),
        .validTri_R11H    (valid_out),
        .bbox_halt_RnnnnL (bbox),
        .occupancy_RnnnnU (occ),
        .tri_count_RnnnnU (tcount)
    );

    int q[$];
    int src_k;
    int cnt_exp;
    bit halt_exp;
    int n_vec;
    int n_err;
    int max_occ;

    task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [FW-1:0] exp_pack(input int k);
        logic [FW-1:0] r;
        r = '0;
        for (int v = 0; v < VERTS; v++)
            for (int a = 0; a < AXIS; a++)
                r[(v*AXIS+a)*SIGFIG +: SIGFIG] = SIGFIG'(k*16 + v*4 + a);
        for (int c = 0; c < COLORS; c++)
            r[(VERTS*AXIS+c)*SIGFIG +: SIGFIG] = SIGFIG'(k*1000 + c*7 + 5);
        return r;
    endfunction

    function automatic logic [FW-1:0] dut_pack();
        logic [FW-1:0] r;
        r = '0;
        for (int v = 0; v < VERTS; v++)
            for (int a = 0; a < AXIS; a++)
                r[(v*AXIS+a)*SIGFIG +: SIGFIG] = tri_out[v][a];
        for (int c = 0; c < COLORS; c++)
            r[(VERTS*AXIS+c)*SIGFIG +: SIGFIG] = color_out[c];
        return r;
    endfunction

    task automatic drive_src(input bit v_on);
        for (int v = 0; v < VERTS; v++)
            for (int a = 0; a < AXIS; a++)
                tri_in[v][a] = v_on ? SIGFIG'(src_k*16 + v*4 + a) : SIGFIG'($urandom);
        for (int c = 0; c < COLORS; c++)
            color_in[c] = v_on ? SIGFIG'(src_k*1000 + c*7 + 5) : SIGFIG'($urandom);
    endtask

    // Called #1 after a rising edge: check outputs, apply inputs, advance model.
    task automatic cycle(input bit r, input bit v_on, input bit bh);
        bit do_pop;
        bit do_push;
        chk("halt", halt_out, halt_exp);
        chk("valid", valid_out, q.size() != 0);
        chk("occupancy", occ, q.size());
        chk("tri_count", tcount, cnt_exp);
        if (int'(occ) > max_occ) max_occ = int'(occ);
        rst  = r;
        vin  = v_on;
        bbox = bh;
        drive_src(v_on);
        if (r) begin
            q.delete();
            cnt_exp  = 0;
            halt_exp = 1'b0;
        end else begin
            do_pop  = (q.size() != 0) && bh;
            do_push = v_on && halt_exp;
            if (do_pop) begin
                chk("head", dut_pack(), exp_pack(q[0]));
                void'(q.pop_front());
            end
            if (do_push) begin
                q.push_back(src_k);
                src_k++;
                cnt_exp++;
            end
            halt_exp = (q.size() < DEPTH);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && q.size() != 0; i++) cycle(1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        n_vec = 0; n_err = 0; src_k = 0; cnt_exp = 0; halt_exp = 1'b0; max_occ = 0;
        rst = 1'b1; vin = 1'b0; bbox = 1'b0;
        drive_src(1'b0);
        repeat (2) @(posedge clk);
        #1;

        // Reset held with a valid source.
        repeat (3) cycle(1'b1, 1'b1, 1'b0);

        // Pass-through: 8 back-to-back with bbox always accepting.
        for (int i = 0; i < 30 && src_k < 8; i++) cycle(1'b0, 1'b1, 1'b1);
        repeat (3) cycle(1'b0, 1'b0, 1'b1);
        chk("pt_max_occ", max_occ, 1);
        chk("pt_count", tcount, 8);
        chk("pt_occ_end", occ, 0);

        // Fill: bbox halted, source offers 6.
        repeat (6) cycle(1'b0, 1'b1, 1'b0);
        chk("fill_occ", occ, 4);
        chk("fill_halt", halt_out, 0);
        chk("fill_acc", tcount, 12);

        // Drain from full: one pop frees a slot for the held triangle.
        cycle(1'b0, 1'b1, 1'b1);
        chk("drain_halt", halt_out, 1);
        chk("drain_occ3", occ, 3);
        cycle(1'b0, 1'b1, 1'b0);
        chk("drain_acc", tcount, 13);
        drain();
        chk("drain_occ", occ, 0);

        // Wrap: 20 triangles with random gaps and random bbox stalls.
        cycle(1'b1, 1'b0, 1'b0);
        src_k = 0;
        for (int i = 0; i < 400 && src_k < 20; i++)
            cycle(1'b0, ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1);
        cycle(1'b0, 1'b0, 1'b1);
        drain();
        chk("wrap_count", tcount, 20);
        chk("wrap_occ", occ, 0);

        // Mid-operation reset with 3 entries stored.
        repeat (3) cycle(1'b0, 1'b1, 1'b0);
        chk("mr_occ3", occ, 3);
        cycle(1'b1, 1'b0, 1'b1);
        chk("mr_valid", valid_out, 0);
        chk("mr_occ", occ, 0);
        chk("mr_count", tcount, 0);
        repeat (2) cycle(1'b0, 1'b1, 1'b0);
        chk("mr_push_count", tcount, 1);
        drain();
        chk("mr_occ_end", occ, 0);
        cycle(1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
